// File: rtl/tetris_pkg.sv
// Shared playfield definitions: board geometry defaults and the curtain
// sequencer state type.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int ROW_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } curtain_state_t;

endpackage

// File: rtl/tick_divider.sv
// Counts tick pulses and emits a 1-cycle strobe on every Nth tick.
// A synchronous clear returns the count to zero and suppresses the strobe.
module tick_divider #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic strobe
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign strobe = tick && !clear && (cnt_q == LAST);

endmodule

// File: rtl/gameover_curtain_ctrl.sv
// Game-over curtain sequencer: covers rows top-down at a frame-paced rate,
// holds the fully covered board, and releases on restart after a minimum hold.
module gameover_curtain_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS           = BOARD_ROWS,
  parameter int FRAMES_PER_ROW = 4,
  parameter int HOLD_FRAMES    = 60
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic             gameover_trig,
  input  logic             restart,
  input  logic             draw_valid,
  input  logic [ROW_W-1:0] draw_row,
  output logic             row_gameover,
  output logic [ROW_W-1:0] cover_rows,
  output logic             freeze,
  output logic             done,
  output curtain_state_t   state
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CW-1:0]    ROWS_C    = CW'(ROWS);
  localparam logic [ROW_W-1:0] ROWS_R    = ROW_W'(ROWS);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_FRAMES);

  curtain_state_t state_q, state_d;
  logic [CW-1:0]  cover_q, cover_d, cover_inc;
  logic [HW-1:0]  hold_q, hold_d;
  logic           freeze_q, done_q, row_go_q;
  logic           row_strobe;

  // Row pacing only runs in FILL; outside FILL the divider is held cleared,
  // so a tick coinciding with the trigger is never counted.
  tick_divider #(.N(FRAMES_PER_ROW)) u_row_div (
    .clk    (Clk),
    .rst    (Reset),
    .clear  (state_q != FILL),
    .tick   (frame_tick && (state_q == FILL)),
    .strobe (row_strobe)
  );

  assign cover_inc = cover_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cover_d = cover_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (gameover_trig) begin
          state_d = FILL;
          cover_d = '0;
          hold_d  = '0;
        end
      end
      FILL: begin
        if (row_strobe) begin
          cover_d = cover_inc;
          if (cover_inc == ROWS_C) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
      end
      HOLD: begin
        // Exit takes priority over a coincident tick once the hold has expired.
        if (restart && (hold_q == HOLD_LAST)) begin
          state_d = IDLE;
          cover_d = '0;
        end else if (frame_tick && (hold_q != HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cover_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cover_q  <= '0;
      hold_q   <= '0;
      freeze_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cover_q  <= cover_d;
      hold_q   <= hold_d;
      freeze_q <= (state_d != IDLE);
      done_q   <= (state_d == HOLD);
    end
  end

  // Compare against the pre-update cover count; renderer aligns by one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_go_q <= 1'b0;
    end else begin
      row_go_q <= draw_valid && (draw_row < ROWS_R) &&
                  (draw_row < ROW_W'(cover_q));
    end
  end

  assign row_gameover = row_go_q;
  assign cover_rows   = ROW_W'(cover_q);
  assign freeze       = freeze_q;
  assign done         = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_gameover_curtain_ctrl.sv
// Bench for gameover_curtain_ctrl: directed scenarios followed by random
// stimulus, all checked against a frame-count reference model.
module tb_gameover_curtain_ctrl;
  import tetris_pkg::*;

  localparam int ROWS = 20;
  localparam int FPR  = 4;
  localparam int HF   = 60;

  logic           Clk = 1'b0;
  logic           Reset, frame_tick, gameover_trig, restart, draw_valid;
  logic [4:0]     draw_row;
  logic           row_gameover, freeze, done;
  logic [4:0]     cover_rows;
  curtain_state_t state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0/1/2 = idle/fill/hold; coverage derived from
  // the number of frame ticks seen since the curtain started.
  int phase, fill_ticks, hold_ticks;
  logic [0:0] exp_q[$];

  gameover_curtain_ctrl #(.ROWS(ROWS), .FRAMES_PER_ROW(FPR), .HOLD_FRAMES(HF)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .gameover_trig (gameover_trig),
    .restart       (restart),
    .draw_valid    (draw_valid),
    .draw_row      (draw_row),
    .row_gameover  (row_gameover),
    .cover_rows    (cover_rows),
    .freeze        (freeze),
    .done          (done),
    .state         (state)
  );

  always #5 Clk = ~Clk;

  function automatic int model_cover();
    return (phase == 0) ? 0 : fill_ticks / FPR;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic tk, input logic trg,
                      input logic rs, input logic dv, input logic [4:0] dr);
    int cov_before;
    curtain_state_t exp_state;
    Reset         = rst;
    frame_tick    = tk;
    gameover_trig = trg;
    restart       = rs;
    draw_valid    = dv;
    draw_row      = dr;
    @(posedge Clk);
    cov_before = model_cover();
    exp_q.push_back(!rst && dv && (int'(dr) < ROWS) && (int'(dr) < cov_before));
    if (rst) begin
      phase = 0; fill_ticks = 0; hold_ticks = 0;
    end else begin
      case (phase)
        0: if (trg) begin phase = 1; fill_ticks = 0; end
        1: if (tk) begin
             fill_ticks++;
             if (fill_ticks == ROWS * FPR) begin phase = 2; hold_ticks = 0; end
           end
        default: begin
          if (rs && hold_ticks == HF) begin
            phase = 0; fill_ticks = 0;
          end else if (tk && hold_ticks < HF) begin
            hold_ticks++;
          end
        end
      endcase
    end
    exp_state = (phase == 0) ? IDLE : (phase == 1) ? FILL : HOLD;
    #1;
    check("row_gameover", 32'(row_gameover), 32'(exp_q.pop_front()));
    check("cover_rows",   32'(cover_rows),   model_cover());
    check("freeze",       32'(freeze),       32'(phase != 0));
    check("done",         32'(done),         32'(phase == 2));
    check("state",        32'(state),        32'(exp_state));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 24)));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 5'd0);
  endtask

  initial begin
    phase = 0; fill_ticks = 0; hold_ticks = 0;
    step(1, 0, 0, 0, 1, 5'd0);
    step(1, 1, 0, 1, 1, 5'd3);
    check("reset_cover", 32'(cover_rows), 0);

    // Full curtain: 80 ticks, cover steps every 4 ticks.
    step(0, 0, 1, 0, 0, 5'd0);
    check("t1_freeze_after_trig", 32'(freeze), 1);
    for (int i = 1; i <= ROWS * FPR; i++) begin
      step(0, 1, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 24)));
      check("t1_cover_step", 32'(cover_rows), i / FPR);
      idle_cycles(2);
    end
    check("t1_cover_full", 32'(cover_rows), ROWS);
    check("t1_done", 32'(done), 1);

    // Hold: early restart ignored, late restart (with coincident tick) exits.
    ticks(30);
    step(0, 0, 0, 1, 0, 5'd0);
    check("t3_early_restart", 32'(state), 32'(HOLD));
    ticks(29);
    step(0, 0, 0, 1, 0, 5'd0);
    check("t3_restart_at_59", 32'(done), 1);
    step(0, 1, 0, 0, 0, 5'd0);
    ticks(3);
    step(0, 1, 0, 1, 0, 5'd0);
    check("t3_exit_cover", 32'(cover_rows), 0);
    check("t3_exit_freeze", 32'(freeze), 0);
    check("t3_exit_done", 32'(done), 0);
    step(0, 1, 0, 1, 0, 5'd0);
    check("t3_idle_restart", 32'(freeze), 0);

    // Trigger with coincident tick: the tick is not counted.
    step(0, 1, 1, 0, 0, 5'd0);
    check("t4_state_fill", 32'(state), 32'(FILL));
    ticks(3);
    check("t4_not_yet", 32'(cover_rows), 0);
    ticks(1);
    check("t4_first_row", 32'(cover_rows), 1);
    step(0, 0, 1, 0, 0, 5'd0);
    check("t4_retrig_ignored", 32'(cover_rows), 1);
    ticks(16);
    check("t2_cover5", 32'(cover_rows), 5);

    // Row select against cover_rows=5.
    step(0, 0, 0, 0, 1, 5'd4);
    check("t2_row4", 32'(row_gameover), 1);
    step(0, 0, 0, 0, 1, 5'd5);
    check("t2_row5", 32'(row_gameover), 0);
    step(0, 0, 0, 0, 1, 5'd25);
    check("t2_row25", 32'(row_gameover), 0);

    // Row being covered this cycle shows only on the next fetch.
    ticks(3);
    step(0, 1, 0, 0, 1, 5'd5);
    check("t6_same_cycle", 32'(row_gameover), 0);
    check("t6_cover6", 32'(cover_rows), 6);
    step(0, 0, 0, 0, 1, 5'd5);
    check("t6_next_fetch", 32'(row_gameover), 1);

    // Reset mid-fill, then restart from row 0.
    ticks(24);
    check("t5_cover12", 32'(cover_rows), 12);
    step(1, 1, 0, 0, 1, 5'd0);
    check("t5_reset_cover", 32'(cover_rows), 0);
    check("t5_reset_row", 32'(row_gameover), 0);
    check("t5_reset_freeze", 32'(freeze), 0);
    step(0, 0, 1, 0, 0, 5'd0);
    ticks(4);
    check("t5_restart_row1", 32'(cover_rows), 1);

    // Random stimulus.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 1499) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 27)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
